rr_arbiter_8: RTL

Round-robin arbiter that shares one 3-to-8 decoded resource among eight requesters. It registers a 3-bit grant index plus a valid bit, and drives a one-hot grant vector decoded from that index under enable. It sits in front of the `decoder_3_8` select path, so each requester sees exactly one select line at a time. A programmable hold limit stops any single requester from monopolising the resource.

---
 rtl/rr_arbiter_8_if.sv | 30 +++
 rtl/rr_arbiter_8.sv | 104 ++++++++++
 2 files changed

// File: rtl/rr_arbiter_8_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_8_if
// Purpose  : Request/grant bundle between eight requesters and rr_arbiter_8.
// Revision : 1.0
// ============================================================================
interface rr_arbiter_8_if;
    logic       en;
    logic [7:0] req;
    logic       gnt_vld;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;

    modport master (
        output en,
        output req,
        input  gnt_vld,
        input  gnt_idx,
        input  gnt
    );

    modport slave (
        input  en,
        input  req,
        output gnt_vld,
        output gnt_idx,
        output gnt
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_8
// Purpose  : Eight-way round-robin arbiter with a programmable hold limit.
// Revision : 1.0
// ============================================================================
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    rr_arbiter_8_if.slave    bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] c_HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;

    logic [3:0] w_win_all;
    logic [3:0] w_win_oth;
    logic [3:0] w_cnt_inc;
    logic [3:0] w_dec_lo;

    // Returns {found, index}; the search begins one past start and ends on start.
    function automatic logic [3:0] f_search(input logic [7:0] mask, input logic [2:0] start);
        logic [2:0] idx;
        f_search = 4'h0;
        for (int k = 8; k >= 1; k--) begin
            idx = start + 3'(k);
            if (mask[idx]) begin
                f_search = {1'b1, idx};
            end
        end
    endfunction

    assign w_win_all = f_search(bus.req, ptr_q);
    assign w_win_oth = f_search(bus.req & ~(8'b1 << gnt_idx_q), ptr_q);
    assign w_cnt_inc = (hold_cnt_q == 4'hF) ? hold_cnt_q : hold_cnt_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_idx_q  <= 3'd0;
            ptr_q      <= 3'd7;
            hold_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.en && w_win_all[3]) begin
                    state_d    = ST_GRANT;
                    gnt_idx_d  = w_win_all[2:0];
                    ptr_d      = w_win_all[2:0];
                    hold_cnt_d = 4'd0;
                end
            end
            ST_GRANT: begin
                hold_cnt_d = w_cnt_inc;
                if (!bus.en) begin
                    state_d = ST_IDLE;
                end else if (!bus.req[gnt_idx_q] ||
                             ((hold_cnt_q == c_HOLD_LAST) && w_win_oth[3])) begin
                    // Release or forced rotation: hand over on this edge if anyone waits.
                    if (w_win_oth[3]) begin
                        gnt_idx_d  = w_win_oth[2:0];
                        ptr_d      = w_win_oth[2:0];
                        hold_cnt_d = 4'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Two-bank decode: gnt_idx[2] enables the upper or lower nibble.
    assign w_dec_lo    = 4'b0001 << gnt_idx_q[1:0];
    assign bus.gnt_vld = (state_q == ST_GRANT);
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt     = {(bus.gnt_vld &&  gnt_idx_q[2]) ? w_dec_lo : 4'h0,
                          (bus.gnt_vld && !gnt_idx_q[2]) ? w_dec_lo : 4'h0};

endmodule
`default_nettype wire
